// File: rtl/cipher_cfg_pkg.sv
// Shared types and constants for the dual XOR cipher configuration sequencer.
package cipher_cfg_pkg;

   // Sequencer states; encoding is fixed so debug probes decode consistently.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SHIFT  = 2'b01,
      ST_SETTLE = 2'b10,
      ST_RUN    = 2'b11
   } cfg_state_t;

   // Default LFSR width of each tx/rx taps/state field.
   localparam int DEFAULT_M = 32;

   // Chain length for a given field width: four M-bit fields plus two mux bits.
   function automatic int cfg_width(input int m);
      return (4 * m) + 2;
   endfunction

   // Field offsets inside the configuration word for the default field width.
   // Bit 0 is shifted out first and ends up at the chain tail.
   localparam int RX_STATE_LSB = 0;
   localparam int RX_TAPS_LSB  = DEFAULT_M;
   localparam int TX_STATE_LSB = 2 * DEFAULT_M;
   localparam int TX_TAPS_LSB  = 3 * DEFAULT_M;
   localparam int MUX_EN_D     = 4 * DEFAULT_M;
   localparam int MUX_EXT_A    = (4 * DEFAULT_M) + 1;

   // Field offsets for an arbitrary field width m.
   function automatic int rx_taps_lsb(input int m);
      return m;
   endfunction

   function automatic int tx_state_lsb(input int m);
      return 2 * m;
   endfunction

   function automatic int tx_taps_lsb(input int m);
      return 3 * m;
   endfunction

   function automatic int mux_en_d_bit(input int m);
      return 4 * m;
   endfunction

   function automatic int mux_ext_a_bit(input int m);
      return (4 * m) + 1;
   endfunction

endpackage : cipher_cfg_pkg

// File: rtl/cipher_cfg_sequencer_shift_engine.sv
// Parallel-load / serial shift register with its bit counter.
// Bit 0 leaves first; the return bit enters at the top, so after W shifts
// the register holds the chain's previous contents in chain order.
module cfg_shift_engine #(
   parameter  int W  = 130,
   localparam int CW = $clog2(W + 1)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic [W-1:0] i_word,
   input  logic         i_ser,
   output logic [W-1:0] o_q,
   output logic         o_last
);

   logic [W-1:0]  r_shreg;
   logic [CW-1:0] r_cnt;

   // Shift register and bit counter: load restarts the count, shift advances it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shreg <= {W{1'b0}};
         r_cnt   <= {CW{1'b0}};
      end else if (i_load) begin
         r_shreg <= i_word;
         r_cnt   <= {CW{1'b0}};
      end else if (i_shift) begin
         r_shreg <= {i_ser, r_shreg[W-1:1]};
         r_cnt   <= r_cnt + CW'(1);
      end else begin
         r_shreg <= r_shreg;
         r_cnt   <= r_cnt;
      end
   end

   assign o_q    = r_shreg;
   assign o_last = (r_cnt == CW'(W - 1));

endmodule : cfg_shift_engine

// File: rtl/cipher_cfg_sequencer.sv
// Configuration sequencer for the dual XOR cipher: shifts a host config word
// into the serial chain, captures the old chain contents as readback, and
// gates the cipher enable so it never overlaps the chain shift enable.
module cipher_cfg_sequencer
   import cipher_cfg_pkg::*;
#(
   parameter  int M      = 32,
   parameter  int SETTLE = 2,
   localparam int CFG_W  = cfg_width(M),
   localparam int SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [CFG_W-1:0] i_cfg_word,
   input  logic             i_cfg_start,
   input  logic             i_run_req,
   output logic             o_busy,
   output logic             o_done,
   output logic [CFG_W-1:0] o_readback,
   output logic             o_cfg_en,
   output logic             o_cfg_o,
   input  logic             i_cfg_i,
   output logic             o_en,
   output logic [7:0]       o_load_count
);

   cfg_state_t       r_state;
   cfg_state_t       w_next_state;
   logic [SW-1:0]    r_settle_cnt;
   logic             w_settle_last;
   logic             w_settle_exit;
   logic             w_load;
   logic             w_shift;
   logic             w_shift_last;
   logic [CFG_W-1:0] w_q;
   logic             r_done;
   logic [CFG_W-1:0] r_readback;
   logic [7:0]       r_load_count;

   cfg_shift_engine #(
      .W (CFG_W)
   ) u_shift_engine (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_word  (i_cfg_word),
      .i_ser   (i_cfg_i),
      .o_q     (w_q),
      .o_last  (w_shift_last)
   );

   assign w_shift       = (r_state == ST_SHIFT);
   assign w_settle_last = (r_settle_cnt == SW'(SETTLE - 1));
   assign w_settle_exit = (r_state == ST_SETTLE) && w_settle_last;

   // Next-state decode; cfg_start is honoured only in IDLE and RUN.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_cfg_start) begin
               w_next_state = ST_SHIFT;
               w_load       = 1'b1;
            end else if (i_run_req && (r_load_count != 8'd0)) begin
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (w_shift_last) begin
               w_next_state = ST_SETTLE;
            end else begin
               w_next_state = ST_SHIFT;
            end
         end
         ST_SETTLE: begin
            if (w_settle_last) begin
               w_next_state = i_run_req ? ST_RUN : ST_IDLE;
            end else begin
               w_next_state = ST_SETTLE;
            end
         end
         ST_RUN: begin
            if (i_cfg_start) begin
               w_next_state = ST_SHIFT;
               w_load       = 1'b1;
            end else if (!i_run_req) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RUN;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_load       = 1'b0;
         end
      endcase
   end

   // State register; reset aborts any shift in progress.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Settle counter: counts idle cycles after the last shift, zero elsewhere.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_settle_cnt <= {SW{1'b0}};
      end else if ((r_state == ST_SETTLE) && !w_settle_last) begin
         r_settle_cnt <= r_settle_cnt + SW'(1);
      end else begin
         r_settle_cnt <= {SW{1'b0}};
      end
   end

   // Completion bookkeeping: done pulse, readback capture and load counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_done       <= 1'b0;
         r_readback   <= {CFG_W{1'b0}};
         r_load_count <= 8'd0;
      end else if (w_settle_exit) begin
         r_done       <= 1'b1;
         r_readback   <= w_q;
         r_load_count <= r_load_count + 8'd1;
      end else begin
         r_done       <= 1'b0;
         r_readback   <= r_readback;
         r_load_count <= r_load_count;
      end
   end

   // All outputs come from registered state only; en and cfg_en decode
   // from mutually exclusive states so they can never be high together.
   assign o_busy       = (r_state == ST_SHIFT) || (r_state == ST_SETTLE);
   assign o_cfg_en     = (r_state == ST_SHIFT);
   assign o_cfg_o      = (r_state == ST_SHIFT) & w_q[0];
   assign o_en         = (r_state == ST_RUN);
   assign o_done       = r_done;
   assign o_readback   = r_readback;
   assign o_load_count = r_load_count;

endmodule : cipher_cfg_sequencer

// File: doc/cipher_cfg_sequencer.md
Name: cipher_cfg_sequencer

Overview:
Controller for the dual XOR cipher's serial configuration chain (4*M+2 bits: mux_ext_a, mux_en_d, tx taps, tx state, rx taps, rx state).
- Accepts a parallel config word from the host and shifts it LSB-first into the chain.
- Captures the chain's previous contents as readback.
- Gates the cipher enable so that en and cfg_en are never high together.
- Sits between the host/register interface and the dual XOR core, replacing ad-hoc stimulus sequencing.

Parameters:
M, 32, LFSR width of each tx/rx taps/state field.
SETTLE, 2, idle cycles between end of shift and done/run (min 1).
CFG_W, 4*M+2, derived localparam: chain length. Not overridable.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
cfg_word  in  CFG_W  config to load; sampled only on the accepted cfg_start edge
cfg_start  in  1  request a (re)configuration; single-cycle or level
run_req  in  1  level; high = cipher should run once configured
busy  out  1  high in SHIFT and SETTLE
done  out  1  one-cycle pulse when a configuration completes
readback  out  CFG_W  chain contents prior to the last completed load
cfg_en  out  1  chain shift enable, to the core's cfg_en
cfg_o  out  1  serial data to the core's cfg_i
cfg_i  in  1  serial return from the core's cfg_o (chain tail)
en  out  1  cipher run enable, to the core's en
load_count  out  8  number of completed loads; wraps at 255 -> 0

Behaviour:
Reset (rst high at an edge):
- State goes to IDLE.
- busy, done, cfg_en and en are 0; readback and load_count are 0.
- The shift register clears to 0, so cfg_o is 0.
- Reset takes priority over every other input and aborts any shift in progress. The chain is then left partially shifted; the host must reload.

State machine (registered; all outputs decoded from registered state, no combinational input-to-output paths):
- IDLE:
  - cfg_start=1 -> SHIFT. The same edge loads shreg <= cfg_word and cnt <= 0.
  - Otherwise, run_req=1 and load_count != 0 -> RUN.
  - Otherwise, stay in IDLE.
- SHIFT:
  - cfg_en=1 and cfg_o=shreg[0].
  - Each cycle: shreg <= {cfg_i, shreg[CFG_W-1:1]}; cnt <= cnt+1.
  - Exactly CFG_W cycles. When cnt==CFG_W-1 -> SETTLE.
  - cfg_start is ignored here.
- SETTLE:
  - cfg_en=0; lasts SETTLE cycles (separate counter).
  - On exit: readback <= shreg; load_count += 1; done pulses in the next cycle.
  - Next state is RUN if run_req=1 at the exit edge, else IDLE.
  - cfg_start is ignored here.
- RUN:
  - en=1.
  - cfg_start=1 -> SHIFT (load as in IDLE). en is 0 from the next cycle, so en and cfg_en are never both high.
  - Otherwise, run_req=0 -> IDLE.
  - cfg_start has priority over run_req.

Timing and invariants:
- Latency from the cfg_start edge to done high is CFG_W+SETTLE+1 cycles.
- en rises in the same cycle as done when run_req is high.
- After a load, the chain holds cfg_word bit-exact: chain bit k = cfg_word[k].
- cnt width is clog2(CFG_W+1). No wrap occurs within a load.
- cfg_start held high through a load causes an immediate reload only if it is still high in IDLE or RUN after done. This is intended; the host uses a pulse.

Decomposition:
Package cipher_cfg_pkg holds:
- the state enum (IDLE=2'b00, SHIFT=2'b01, SETTLE=2'b10, RUN=2'b11);
- a function cfg_width(M) returning 4*M+2;
- field offset constants: RX_STATE_LSB=0, RX_TAPS_LSB=M, TX_STATE_LSB=2M, TX_TAPS_LSB=3M, MUX_EN_D=4M, MUX_EXT_A=4M+1.

One sub-module, cfg_shift_engine: the CFG_W-bit parallel-load/serial shift register plus its bit counter. It exposes load, shift, last and q. The FSM, settle counter, readback, load_count and en stay in the top level.

Test Plan:
- Reset: apply rst for 3 cycles -> busy=done=cfg_en=en=cfg_o=0, readback=0, load_count=0. Then run_req=1 -> en stays 0 because no load has occurred.
- Single load, M=32, against a behavioural 130-bit chain model preset to all-ones:
  - Stimulus: cfg_word={2'b10, 32'h48000000, 32'h00000077, 32'h60, 32'h1}.
  - Required: cfg_en high for exactly 130 cycles; done at cycle 133 after cfg_start; model equals cfg_word; readback equals all-ones; load_count=1.
- Back-to-back loads: load A=all 0xA5 pattern, then B=~A -> after the second done, readback==A and the chain model==B.
- Run gating: run_req=1 during the load -> en=1 in the done cycle. Then run_req=0 -> en=0 on the next cycle and state is IDLE.
- Reconfigure while running: cfg_start in RUN -> en falls the next cycle and cfg_en rises in that same cycle, never overlapping. cfg_start pulses during SHIFT/SETTLE are ignored: exactly 130 shift cycles and one done.
- Reset mid-shift: rst at shift cycle 50 -> all outputs return to reset values the next cycle. A following full load then produces a correct chain.
